spi_master_arbiter: RTL and testbench
=====================================

# spi_master_arbiter

Round-robin scheduler that shares one SPI master channel between N independent requesters. Each requester posts an M-bit word; the arbiter picks one requester, presents its word on the master's parallel input, pulses the master start, waits for the frame to finish (LOAD handshake), captures the received word and returns it to the winner with a one-cycle done strobe. It sits between client logic and the SPI master, replacing the single hand-driven `st`/`DI` pair at board top level.

## Interface
- `M`, 15: SPI frame width in bits; same value as the master's `m`.
- `N`, 4: number of requesters, 2..8.
- `TO`, 255: watchdog limit in `clk` cycles for each wait state; 8-bit counter.
- `clk` in 1: system clock; all logic on the rising edge.
- `clr` in 1: reset, asynchronous, active-low. Asserted (0) forces the reset state immediately.
- `req` in N: request flags, one per requester; level-sensitive, held until `done[i]`.
- `tx_dat` in N*M: packed TX words; requester i occupies bits [i*M +: M].
- `gnt` out N: one-hot grant; all-zero when idle.
- `done` out N: one-cycle strobe to the winner when its frame completes or aborts.
- `err` out 1: valid with `done`; 1 = watchdog abort, `rx_dat` invalid.
- `rx_dat` out M: word received in the last frame; held until the next capture.
- `st` out 1: start pulse to the SPI master, exactly one cycle wide.
- `DI` out M: parallel TX word to the master; registered.
- `LOAD` in 1: master frame signal; 1 = idle/frame boundary, 0 = shifting.
- `DO` in M: master parallel RX word; valid on the `LOAD` 0->1 edge.
- `busy` out 1: 1 in every state except IDLE.

## Operation
- States: IDLE, START, WAIT_LO, WAIT_HI, DONE.
- IDLE: if any `req` bit is set, select the first set bit scanning upward from `last+1` (mod N). `last` is the index of the previous winner; its reset value is N-1, so requester 0 has first priority after reset. Register `gnt`, latch that requester's word into `DI`, and go to START.
- START: drive `st`=1 for this single cycle, clear the watchdog, go to WAIT_LO.
- WAIT_LO: wait for `LOAD`=0, then go to WAIT_HI. If the watchdog reaches `TO`, go to DONE with the abort flag set.
- WAIT_HI: wait for `LOAD`=1 (frame end). Capture `DO` into `rx_dat` in the same cycle `LOAD`=1 is sampled, then go to DONE. Watchdog abort works as in WAIT_LO.
- DONE: `done[gnt_idx]`=1 and `err`=abort flag for this one cycle. Update `last`=winner, clear `gnt` and the abort flag, return to IDLE.
- `DI` and `gnt` stay stable from START through DONE. Changes on `tx_dat` or `req` during a frame are ignored.
- If the winner drops `req` mid-frame, the frame still completes and `done` is still issued.
- Each requester may re-request right after its `done`. Round-robin guarantees every other pending requester is served before that requester is served again.
- The watchdog counts from 0 in WAIT_LO and WAIT_HI and resets on every state entry. Abort happens at count == `TO`.
- Reset values: state=IDLE, `gnt`=0, `done`=0, `err`=0, `st`=0, `busy`=0, `DI`=0, `rx_dat`=0, `last`=N-1, watchdog=0.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. No `done` is issued. The master is reset by the same `clr` net at board level.

## Timing
- Request to `st`: `req` sampled in IDLE at edge k, `st`=1 during cycle k+1 (START).
- `st` to `done`: two cycles plus the master frame time. WAIT_LO exits on the first edge with `LOAD`=0; WAIT_HI exits on the first edge with `LOAD`=1.
- `done` and `rx_dat` update on the same edge. `rx_dat` is valid from that cycle onward.
- Minimum turnaround: IDLE is re-entered the cycle after DONE. The next grant appears one cycle later, so there are at least 2 idle cycles between back-to-back `st` pulses.
- Abort latency: `TO`+1 cycles after entering a wait state.
- Combinational paths: none from `req`/`LOAD` to outputs. All outputs are registered.

## Test plan
- Reset: hold `clr`=0 with `req`=4'b1111. Required: all outputs 0, `busy`=0. Release `clr`; `gnt`=4'b0001 two edges later and `st` pulses once.
- Single transfer: `req[2]`=1, `tx_dat[2]`=15'h2A5A, slave returns 15'h1234. Required: `DI`=15'h2A5A held through the frame, `done`=4'b0100, `err`=0, `rx_dat`=15'h1234.
- Fairness: `req`=4'b1011 held continuously. Required grant order 0,1,3,0,1,3 with exactly one `done` per grant.
- Watchdog: `LOAD` tied to 1, `req[0]`=1, `TO`=255. Required: `done[0]` with `err`=1 exactly 257 cycles after `st`, then `busy`=0.
- Reset mid-frame: assert `clr`=0 during WAIT_HI. Required: `gnt`=0 and `busy`=0 immediately, no `done` pulse. After release, the pending request is re-granted with requester 0 priority.
- Request withdrawn: drop `req[1]` during WAIT_LO. Required: the frame completes, `done[1]` pulses, `rx_dat` is updated.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master between N requesters:
// it grants one requester, starts a frame, waits for LOAD, then returns the RX word.
module spi_master_arbiter #(
    parameter int M  = 15,
    parameter int N  = 4,
    parameter int TO = 255
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   req,
    input  logic [N*M-1:0] tx_dat,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           err,
    output logic [M-1:0]   rx_dat,
    output logic           st,
    output logic [M-1:0]   DI,
    input  logic           LOAD,
    input  logic [M-1:0]   DO,
    output logic           busy
);

    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [IW-1:0]  last, last_nx;
    logic [IW-1:0]  idx, idx_nx;
    logic [7:0]     wd, wd_nx;
    logic           abort, abort_nx;
    logic [N-1:0]   gnt_nx, done_nx;
    logic           err_nx, st_nx, busy_nx;
    logic [M-1:0]   di_nx, rx_nx;
    logic [IW-1:0]  pick, cand;
    logic           found;

    // First set request scanning upward from last+1, wrapping at N.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last) + k) % N);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        idx_nx   = idx;
        wd_nx    = wd;
        abort_nx = abort;
        gnt_nx   = gnt;
        done_nx  = '0;
        err_nx   = 1'b0;
        st_nx    = 1'b0;
        di_nx    = DI;
        rx_nx    = rx_dat;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    idx_nx       = pick;
                    gnt_nx       = '0;
                    gnt_nx[pick] = 1'b1;
                    di_nx        = tx_dat[int'(pick)*M +: M];
                    st_nx        = 1'b1;
                    state_nx     = S_START;
                end
            end
            S_START: begin
                wd_nx    = '0;
                state_nx = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!LOAD) begin
                    wd_nx    = '0;
                    state_nx = S_WAIT_HI;
                end else if (wd == 8'(TO)) begin
                    abort_nx     = 1'b1;
                    done_nx[idx] = 1'b1;
                    err_nx       = 1'b1;
                    state_nx     = S_DONE;
                end else begin
                    wd_nx = wd + 8'd1;
                end
            end
            S_WAIT_HI: begin
                if (LOAD) begin
                    rx_nx        = DO;
                    done_nx[idx] = 1'b1;
                    err_nx       = abort;
                    state_nx     = S_DONE;
                end else if (wd == 8'(TO)) begin
                    abort_nx     = 1'b1;
                    done_nx[idx] = 1'b1;
                    err_nx       = 1'b1;
                    state_nx     = S_DONE;
                end else begin
                    wd_nx = wd + 8'd1;
                end
            end
            S_DONE: begin
                last_nx  = idx;
                gnt_nx   = '0;
                abort_nx = 1'b0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // done/err/st are registered from the transition into their state.
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_IDLE;
            last   <= IW'(N - 1);
            idx    <= '0;
            wd     <= '0;
            abort  <= 1'b0;
            gnt    <= '0;
            done   <= '0;
            err    <= 1'b0;
            st     <= 1'b0;
            busy   <= 1'b0;
            DI     <= '0;
            rx_dat <= '0;
        end else begin
            state  <= state_nx;
            last   <= last_nx;
            idx    <= idx_nx;
            wd     <= wd_nx;
            abort  <= abort_nx;
            gnt    <= gnt_nx;
            done   <= done_nx;
            err    <= err_nx;
            st     <= st_nx;
            busy   <= busy_nx;
            DI     <= di_nx;
            rx_dat <= rx_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: a frame-level model predicts every
// output each cycle, and directed scenarios pin key values with literals.
module tb_spi_master_arbiter;

    localparam int M  = 15;
    localparam int N  = 4;
    localparam int TO = 255;

    logic           clk = 1'b0;
    logic           clr;
    logic [N-1:0]   req;
    logic [N*M-1:0] tx_dat;
    logic [N-1:0]   gnt, done;
    logic           err, st, busy;
    logic [M-1:0]   rx_dat, DI, DO;
    logic           LOAD;

    spi_master_arbiter #(.M(M), .N(N), .TO(TO)) dut (
        .clk(clk), .clr(clr), .req(req), .tx_dat(tx_dat),
        .gnt(gnt), .done(done), .err(err), .rx_dat(rx_dat),
        .st(st), .DI(DI), .LOAD(LOAD), .DO(DO), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs, computed per edge from the arbitration rules.
    logic [N-1:0] e_gnt, e_done;
    logic         e_err, e_st, e_busy;
    logic [M-1:0] e_di, e_rx;
    int  m_owner, m_last, m_deadline;
    bit  m_closing, m_started, m_low_seen;

    task finish_frame(input bit aborted);
        e_done          = '0;
        e_done[m_owner] = 1'b1;
        e_err           = aborted;
        m_closing       = 1'b1;
    endtask

    task model_step();
        e_st   = 1'b0;
        e_done = '0;
        e_err  = 1'b0;
        if (!clr) begin
            m_owner   = -1;
            m_last    = N - 1;
            m_closing = 1'b0;
            e_gnt     = '0;
            e_di      = '0;
            e_rx      = '0;
            e_busy    = 1'b0;
            return;
        end
        if (m_closing) begin
            m_last    = m_owner;
            m_owner   = -1;
            m_closing = 1'b0;
            e_gnt     = '0;
            e_busy    = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && req[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                e_gnt          = '0;
                e_gnt[m_owner] = 1'b1;
                e_di           = tx_dat[m_owner*M +: M];
                e_st           = 1'b1;
                e_busy         = 1'b1;
                m_started      = 1'b0;
                m_low_seen     = 1'b0;
            end
        end else if (!m_started) begin
            m_started  = 1'b1;
            m_deadline = cyc + TO + 1;
        end else if (!m_low_seen) begin
            if (!LOAD) begin
                m_low_seen = 1'b1;
                m_deadline = cyc + TO + 1;
            end else if (cyc == m_deadline) begin
                finish_frame(1'b1);
            end
        end else begin
            if (LOAD) begin
                e_rx = DO;
                finish_frame(1'b0);
            end else if (cyc == m_deadline) begin
                finish_frame(1'b1);
            end
        end
    endtask

    int st_log[$];
    int done_count = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            if (st) for (int i = 0; i < N; i++) if (gnt[i]) st_log.push_back(i);
            if (|done) done_count++;
            chk("gnt",    32'(gnt),    32'(e_gnt));
            chk("done",   32'(done),   32'(e_done));
            chk("err",    32'(err),    32'(e_err));
            chk("st",     32'(st),     32'(e_st));
            chk("busy",   32'(busy),   32'(e_busy));
            chk("DI",     32'(DI),     32'(e_di));
            chk("rx_dat", 32'(rx_dat), 32'(e_rx));
        end
    end

    // SPI master stand-in: frame starts on st, LOAD low for slave_len cycles.
    bit           slave_on = 1'b1;
    int           slave_lat = 1;
    int           slave_len = 4;
    logic [M-1:0] slave_word = '0;

    initial begin
        LOAD = 1'b1;
        DO   = '0;
        forever begin
            @(negedge clk);
            if (slave_on && clr && st) begin
                for (int i = 0; i < slave_lat && clr; i++) @(negedge clk);
                if (clr) LOAD = 1'b0;
                for (int i = 0; i < slave_len && clr; i++) @(negedge clk);
                DO   = slave_word;
                LOAD = 1'b1;
            end
        end
    end

    task automatic wait_st(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (st) begin ok = 1'b1; break; end
        end
        chk("st_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (|done) begin ok = 1'b1; break; end
        end
        chk("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        bit ok;
        int t0, t1;
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};

        clr    = 1'b0;
        req    = 4'b1111;
        tx_dat = {15'h0333, 15'h0222, 15'h0111, 15'h0ABC};

        // Reset with all requests pending
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_st",   32'(st),   32'd0);
        chk("rst_DI",   32'(DI),   32'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("rel_gnt", 32'(gnt), 32'h1);
        chk("rel_st",  32'(st),  32'd1);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        chk("rel_st_once", 32'(st), 32'd0);
        wait_done(40, ok);

        // Single transfer on requester 2; tx change mid-frame is ignored
        @(negedge clk);
        slave_word           = 15'h1234;
        tx_dat[2*M +: M]     = 15'h2A5A;
        req                  = 4'b0100;
        wait_st(20, ok);
        chk("single_DI",  32'(DI),  32'h2A5A);
        chk("single_gnt", 32'(gnt), 32'h4);
        @(negedge clk);
        tx_dat[2*M +: M] = 15'h5555;
        wait_done(40, ok);
        chk("single_done", 32'(done),   32'h4);
        chk("single_err",  32'(err),    32'd0);
        chk("single_rx",   32'(rx_dat), 32'h1234);
        chk("single_DI_h", 32'(DI),     32'h2A5A);
        @(negedge clk);
        req = '0;

        // Fairness with 4'b1011 held
        do_reset();
        @(negedge clk);
        slave_word = 15'h0A0A;
        st_log.delete();
        done_count = 0;
        req = 4'b1011;
        for (int g = 0; g < 6; g++) wait_st(40, ok);
        wait_done(40, ok);
        @(negedge clk);
        req = '0;
        chk("fair_count", 32'(st_log.size()), 32'd6);
        for (int g = 0; g < 6 && g < st_log.size(); g++)
            chk("fair_order", 32'(st_log[g]), 32'(exp_order[g]));
        chk("fair_dones", 32'(done_count), 32'd6);

        // Watchdog: LOAD never drops
        do_reset();
        @(negedge clk);
        slave_on = 1'b0;
        req      = 4'b0001;
        wait_st(20, ok);
        t0 = cyc;
        wait_done(300, ok);
        t1 = cyc;
        chk("wd_latency", 32'(t1 - t0), 32'd257);
        chk("wd_err",     32'(err),     32'd1);
        chk("wd_done",    32'(done),    32'h1);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        chk("wd_idle", 32'(busy), 32'd0);
        @(negedge clk);
        slave_on = 1'b1;

        // Request withdrawn during WAIT_LO
        @(negedge clk);
        tx_dat[1*M +: M] = 15'h3C3C;
        slave_lat        = 3;
        slave_word       = 15'h0F0F;
        req              = 4'b0010;
        wait_st(20, ok);
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        wait_done(40, ok);
        chk("wdraw_done", 32'(done),   32'h2);
        chk("wdraw_rx",   32'(rx_dat), 32'h0F0F);
        chk("wdraw_err",  32'(err),    32'd0);

        // Reset asserted during WAIT_HI (last winner was 1)
        @(negedge clk);
        slave_lat  = 1;
        slave_len  = 6;
        slave_word = 15'h7001;
        req        = 4'b0110;
        wait_st(20, ok);
        chk("mid_gnt0", 32'(gnt), 32'h4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("mid_gnt",  32'(gnt),  32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("mid_regnt", 32'(gnt), 32'h2);
        @(negedge clk);
        req = '0;
        wait_done(40, ok);
        chk("mid_fin", 32'(done), 32'h2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
